instruction_memory_loadable: RTL and testbench
==============================================

// Module: instruction_memory_loadable
// PURPOSE
//  Parametrised instruction memory for the RISC-V core: word-addressed RAM with a registered fetch
//  port and a program-load port, so programs are loaded at run time rather than hard-wired.
//  Sits between the PC/fetch logic and decode. A load/run FSM gates fetches until loading is done.
//  Misaligned and out-of-range fetches return a NOP and raise an error flag.
// PARAMETERS
//  ADDR_W    32             byte-address width of fetch_addr
//  DATA_W    32             instruction word width
//  DEPTH     64             number of instruction words; power of two, >= 4
//  NOP_INSTR 32'h00000013   word returned on error or out-of-range fetch (addi x0,x0,0)
// PORTS
//  clk             in   1          rising-edge clock
//  reset           in   1          asynchronous, active-high reset
//  load_we         in   1          write load_data into word load_waddr (LOAD state only)
//  load_waddr      in   $clog2(DEPTH)  word index for load writes
//  load_data       in   DATA_W     instruction word to store
//  load_done       in   1          pulse: loading complete; go to RUN
//  load_restart    in   1          pulse: return to LOAD from RUN
//  fetch_req       in   1          fetch request (RUN state only)
//  fetch_addr      in   ADDR_W     byte address from the PC
//  fetch_valid     out  1          fetch_instr is valid this cycle
//  fetch_instr     out  DATA_W     fetched instruction
//  fetch_err       out  1          last fetch was misaligned (fetch_addr[1:0]!=0)
//  fetch_oob       out  1          last fetch word index >= DEPTH
//  running         out  1          FSM is in RUN
//  words_loaded    out  $clog2(DEPTH)+1  count of load writes since entering LOAD; saturates at DEPTH
// BEHAVIOUR
//  - Reset (async, any cycle): state=LOAD, fetch_valid=0, fetch_instr=NOP_INSTR, fetch_err=0,
//    fetch_oob=0, running=0, words_loaded=0. RAM contents are not cleared.
//  - FSM LOAD: load_we writes RAM[load_waddr] on the clock edge and increments words_loaded
//    (saturating at DEPTH). fetch_req is ignored; fetch_valid stays 0. load_done -> RUN next cycle.
//    load_we together with load_done: the write completes, then the FSM goes to RUN.
//  - FSM RUN: running=1. load_we is ignored. load_restart -> LOAD next cycle; words_loaded clears.
//    A fetch_req in the same cycle as load_restart is still served.
//  - Fetch latency is 1 cycle. A fetch_req at edge N gives fetch_valid=1 after edge N+1 with
//    instr/err/oob for that request. Back-to-back requests give one result per cycle.
//    With no request, fetch_valid=0 and fetch_instr holds its last value.
//  - Index = fetch_addr[ADDR_W-1:2]. If fetch_addr[1:0]!=0: fetch_err=1, fetch_instr=NOP_INSTR.
//    Else if index >= DEPTH (upper bits nonzero): fetch_oob=1, fetch_instr=NOP_INSTR.
//    Else fetch_instr=RAM[index]. Both flags are updated on every served fetch.
//  - Read during write at the same index cannot happen, because the two are state-exclusive.
// CONFIGURATION
//  IMEM_BOOT_PROG_EN defined: RAM is initialised with the built-in program and the FSM resets
//   into RUN (running=1). Program, word 0..4: fc002283, 0012f313, 00134393, 00702ee3, ff1ff06f.
//   All other words are 0. load_restart still allows reloading.
//  IMEM_BOOT_PROG_EN undefined: RAM is uninitialised and the FSM resets into LOAD as described above.
// STRUCTURE
//  - Package imem_pkg: typedef enum logic {S_LOAD, S_RUN} imem_state_t; NOP constant;
//    boot program array constant BOOT_PROG[5].
//  - Sub-module imem_ram: simple dual-port RAM (one write port, one registered read port),
//    parameters DEPTH and DATA_W. The top level holds the FSM, the counter, and error/oob muxing.
// TESTING
//  1. Reset, then fetch_req @0x0 -> fetch_valid stays 0 and fetch_instr=0x00000013 (still in LOAD).
//  2. Load words 0..2 = 00100293, 0fc02103, 00110113, then load_done; fetch @0x4 ->
//     one cycle later valid=1, instr=0fc02103; words_loaded=3; running=1.
//  3. In RUN, fetch 0x2 -> err=1, instr=00000013; fetch 0x100 (DEPTH=64) -> oob=1, instr=00000013.
//  4. Back-to-back fetches 0x0, 0x4, 0x8 -> valid on 3 consecutive cycles,
//     instr 00100293, 0fc02103, 00110113.
//  5. Assert reset mid-load after 2 writes -> outputs reset immediately; words_loaded=0; state LOAD.
//  6. Write DEPTH+3 words -> words_loaded=DEPTH; load_restart from RUN -> running=0, words_loaded=0.
//     With IMEM_BOOT_PROG_EN, fetch @0x10 after reset -> ff1ff06f.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// The boot program is used only when IMEM_BOOT_PROG_EN is defined.
package imem_pkg;

    typedef enum logic {S_LOAD, S_RUN} imem_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int BOOT_LEN = 5;

    localparam logic [31:0] BOOT_PROG [BOOT_LEN] = '{
        32'hfc00_2283,
        32'h0012_f313,
        32'h0013_4393,
        32'h0070_2ee3,
        32'hff1f_f06f
    };

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
// IMEM_BOOT_PROG_EN preloads the boot program and zero-fills the other words.
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

`ifdef IMEM_BOOT_PROG_EN
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t boot_image();
        mem_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = '0;
            if (i < BOOT_LEN) img[i] = DATA_W'(BOOT_PROG[i]);
        end
        return img;
    endfunction

    mem_t mem = boot_image();
`else
    logic [DATA_W-1:0] mem [DEPTH];
`endif

    // Program-load write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Fetch read port; holds its word when no read is issued
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: load/run FSM, load counter, fetch checks.
// IMEM_BOOT_PROG_EN: RAM holds the boot program and reset enters RUN.
module instruction_memory_loadable
    import imem_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 64,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_waddr,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_done,
    input  logic                     load_restart,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_instr,
    output logic                     fetch_err,
    output logic                     fetch_oob,
    output logic                     running,
    output logic [$clog2(DEPTH):0]   words_loaded
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef IMEM_BOOT_PROG_EN
    localparam imem_state_t RST_STATE = S_RUN;
`else
    localparam imem_state_t RST_STATE = S_LOAD;
`endif

    imem_state_t       state;
    logic              nop_sel;
    logic [DATA_W-1:0] ram_q;
    logic              served;
    logic              mis;
    logic              hi;
    logic              ram_we;
    logic              ram_re;

    assign served = (state == S_RUN) && fetch_req;
    assign mis    = |fetch_addr[1:0];
    assign hi     = |fetch_addr[ADDR_W-1:AW+2];
    assign ram_we = (state == S_LOAD) && load_we;
    assign ram_re = served && !mis && !hi;

    imem_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (load_waddr),
        .wdata (load_data),
        .re    (ram_re),
        .raddr (fetch_addr[AW+1:2]),
        .rdata (ram_q)
    );

    // Load/run state and saturating load-write counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RST_STATE;
            words_loaded <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (load_we && words_loaded != CW'(DEPTH))
                        words_loaded <= words_loaded + CW'(1);
                    if (load_done) state <= S_RUN;
                end
                S_RUN: begin
                    if (load_restart) begin
                        state        <= S_LOAD;
                        words_loaded <= '0;
                    end
                end
                default: state <= RST_STATE;
            endcase
        end
    end

    // Fetch result flags; nop_sel replaces the RAM word on errors
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_oob   <= 1'b0;
            nop_sel     <= 1'b1;
        end else begin
            fetch_valid <= served;
            if (served) begin
                fetch_err <= mis;
                fetch_oob <= !mis && hi;
                nop_sel   <= mis || hi;
            end
        end
    end

    assign fetch_instr = nop_sel ? NOP_INSTR : ram_q;
    assign running     = (state == S_RUN);

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Randomised self-checking bench for instruction_memory_loadable.
// A cycle-level reference model predicts every output after each edge.
module tb_instruction_memory_loadable;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] NOPW  = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_we;
    logic [AW-1:0] load_waddr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          load_restart;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          fetch_err;
    logic          fetch_oob;
    logic          running;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    instruction_memory_loadable dut (
        .clk          (clk),
        .reset        (reset),
        .load_we      (load_we),
        .load_waddr   (load_waddr),
        .load_data    (load_data),
        .load_done    (load_done),
        .load_restart (load_restart),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_err    (fetch_err),
        .fetch_oob    (fetch_oob),
        .running      (running),
        .words_loaded (words_loaded)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    bit          m_run;
    int          m_cnt;
    bit          m_valid;
    bit          m_err;
    bit          m_oob;
    logic [31:0] m_instr;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
`ifdef IMEM_BOOT_PROG_EN
        m_run = 1'b1;
`else
        m_run = 1'b0;
`endif
        m_cnt   = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_oob   = 1'b0;
        m_instr = NOPW;
    endtask

    // One clock edge of the reference behaviour, from current inputs
    task automatic model_edge();
        int idx;
        if (m_run) begin
            m_valid = fetch_req;
            if (fetch_req) begin
                idx     = int'(fetch_addr >> 2);
                m_err   = fetch_addr[1:0] != 2'b00;
                m_oob   = !m_err && (fetch_addr >> 2) >= 32'(DEPTH);
                m_instr = (m_err || m_oob) ? NOPW : m_mem[idx];
            end
            if (load_restart) begin
                m_run = 1'b0;
                m_cnt = 0;
            end
        end else begin
            m_valid = 1'b0;
            if (load_we) begin
                m_mem[load_waddr] = load_data;
                if (m_cnt < DEPTH) m_cnt++;
            end
            if (load_done) m_run = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   64'(fetch_valid),  64'(m_valid));
        chk({tag, ".instr"},   64'(fetch_instr),  64'(m_instr));
        chk({tag, ".err"},     64'(fetch_err),    64'(m_err));
        chk({tag, ".oob"},     64'(fetch_oob),    64'(m_oob));
        chk({tag, ".running"}, 64'(running),      64'(m_run));
        chk({tag, ".words"},   64'(words_loaded), 64'(m_cnt));
    endtask

    task automatic idle();
        load_we      = 1'b0;
        load_waddr   = '0;
        load_data    = '0;
        load_done    = 1'b0;
        load_restart = 1'b0;
        fetch_req    = 1'b0;
        fetch_addr   = '0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic write_word(input int idx, input logic [31:0] d);
        load_we    = 1'b1;
        load_waddr = AW'(idx);
        load_data  = d;
        step("load");
        load_we    = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input string tag);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step(tag);
        fetch_req  = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        step("done");
        load_done = 1'b0;
    endtask

    task automatic pulse_restart();
        load_restart = 1'b1;
        step("restart");
        load_restart = 1'b0;
    endtask

    initial begin
        int r;
        int kind;
`ifdef IMEM_BOOT_PROG_EN
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_mem[0] = 32'hfc00_2283;
        m_mem[1] = 32'h0012_f313;
        m_mem[2] = 32'h0013_4393;
        m_mem[3] = 32'h0070_2ee3;
        m_mem[4] = 32'hff1f_f06f;
`endif
        idle();
        reset = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

`ifdef IMEM_BOOT_PROG_EN
        fetch(32'h10, "boot");
        chk("boot.instr", 64'(fetch_instr), 64'(32'hff1f_f06f));
        pulse_restart();
`else
        chk("rst.running", 64'(running), 64'd0);
        chk("rst.instr", 64'(fetch_instr), 64'(NOPW));
`endif

        // Fetch while loading is ignored
        fetch(32'h0, "ldfetch");
        chk("ldfetch.valid", 64'(fetch_valid), 64'd0);
        chk("ldfetch.instr", 64'(fetch_instr), 64'(NOPW));

        write_word(0, 32'h0010_0293);
        write_word(1, 32'h0fc0_2103);
        write_word(2, 32'h0011_0113);
        pulse_done();
        chk("run.words", 64'(words_loaded), 64'd3);
        chk("run.running", 64'(running), 64'd1);
        fetch(32'h4, "f4");
        chk("f4.instr", 64'(fetch_instr), 64'(32'h0fc0_2103));
        chk("f4.valid", 64'(fetch_valid), 64'd1);

        fetch(32'h2, "mis");
        chk("mis.err", 64'(fetch_err), 64'd1);
        chk("mis.instr", 64'(fetch_instr), 64'(NOPW));
        fetch(32'h100, "oob");
        chk("oob.flag", 64'(fetch_oob), 64'd1);
        chk("oob.instr", 64'(fetch_instr), 64'(NOPW));

        // Back-to-back fetches
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        step("b2b0");
        chk("b2b0.instr", 64'(fetch_instr), 64'(32'h0010_0293));
        fetch_addr = 32'h4;
        step("b2b1");
        chk("b2b1.instr", 64'(fetch_instr), 64'(32'h0fc0_2103));
        fetch_addr = 32'h8;
        step("b2b2");
        chk("b2b2.instr", 64'(fetch_instr), 64'(32'h0011_0113));
        fetch_req = 1'b0;
        step("hold");
        chk("hold.instr", 64'(fetch_instr), 64'(32'h0011_0113));

        // Async reset in the middle of loading
        pulse_restart();
        write_word(5, 32'h1234_5678);
        write_word(6, 32'h9abc_def0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("midrst");
        chk("midrst.words", 64'(words_loaded), 64'd0);
        @(negedge clk);
        reset = 1'b0;
`ifdef IMEM_BOOT_PROG_EN
        pulse_restart();
`endif

        // Overfill to check saturation, then restart from RUN
        for (int i = 0; i < DEPTH + 3; i++)
            write_word(i % DEPTH, $urandom);
        chk("sat.words", 64'(words_loaded), 64'(DEPTH));
        pulse_done();
        pulse_restart();
        chk("rs.running", 64'(running), 64'd0);
        chk("rs.words", 64'(words_loaded), 64'd0);
        pulse_done();

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            r            = $urandom_range(0, 99);
            kind         = $urandom_range(0, 9);
            load_we      = $urandom_range(0, 1) == 1;
            load_waddr   = AW'($urandom);
            load_data    = $urandom;
            load_done    = r < 6;
            load_restart = r >= 95;
            fetch_req    = $urandom_range(0, 3) != 0;
            if (kind == 0)
                fetch_addr = {$urandom_range(0, 255), 2'b00} |
                             32'($urandom_range(1, 3));
            else if (kind == 1)
                fetch_addr = ($urandom | 32'h100) & 32'hffff_fffc;
            else
                fetch_addr = {24'd0, AW'($urandom), 2'b00};
            step("rand");
        end
        idle();
        step("end");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
